// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding, BCD digit
// limits, counter widths and a helper that validates a BCD alarm time.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } alarm_state_e;

    localparam logic [3:0] BCD_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_ONES_MAX = 4'd9;

    localparam int unsigned CNT_W = 6;
    localparam int unsigned SNZ_W = 3;

    // True when mm:ss digits form a valid time (tens 0..5, ones 0..9).
    function automatic logic bcd_time_legal(
        input logic [3:0] mtens,
        input logic [3:0] mones,
        input logic [3:0] stens,
        input logic [3:0] sones
    );
        return (mtens <= BCD_TENS_MAX) && (mones <= BCD_ONES_MAX) &&
               (stens <= BCD_TENS_MAX) && (sones <= BCD_ONES_MAX);
    endfunction

endpackage

// File: rtl/alarm_sec_cnt.sv
// Seconds counter used for ring and snooze durations.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous clear (wins over tick)
//   tick      - advance by one
//   at_last   - count currently equals LIMIT-1
module alarm_sec_cnt
    import alarm_pkg::*;
#(
    parameter int unsigned LIMIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic at_last
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: stores the BCD alarm time, detects a match against the
// running clock and sequences ringing, snooze and automatic timeout.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   sec_tick                   - one-cycle pulse per second
//   alarm_en                   - arm level
//   ld_alarm, ld_*             - load pulse and BCD digits for the alarm time
//   t_*                        - current clock BCD digits
//   key_snooze, key_dismiss    - decoded key pulses
//   al_*                       - stored alarm digits
//   alarm_ring, alarm_blink    - ringing indicator and its 1 Hz blink
//   alarm_state                - 0 disarmed, 1 armed, 2 ringing, 3 snoozing
//   snooze_left                - snoozes remaining in this alarm event
//   ring_timeout, ld_err       - one-cycle status pulses
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SECS = 10,
    parameter int unsigned RING_SECS   = 30,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       alarm_en,
    input  logic       ld_alarm,
    input  logic [3:0] ld_mtens,
    input  logic [3:0] ld_mones,
    input  logic [3:0] ld_stens,
    input  logic [3:0] ld_sones,
    input  logic [3:0] t_mtens,
    input  logic [3:0] t_mones,
    input  logic [3:0] t_stens,
    input  logic [3:0] t_sones,
    input  logic       key_snooze,
    input  logic       key_dismiss,
    output logic [3:0] al_mtens,
    output logic [3:0] al_mones,
    output logic [3:0] al_stens,
    output logic [3:0] al_sones,
    output logic       alarm_ring,
    output logic       alarm_blink,
    output logic [1:0] alarm_state,
    output logic [2:0] snooze_left,
    output logic       ring_timeout,
    output logic       ld_err
);

    localparam logic [SNZ_W-1:0] SNZ_MAX = SNZ_W'(MAX_SNOOZE);

    alarm_state_e     state_q, state_d;
    logic [3:0]       mtens_q, mtens_d, mones_q, mones_d;
    logic [3:0]       stens_q, stens_d, sones_q, sones_d;
    logic             ring_q, ring_d;
    logic             blink_q, blink_d;
    logic [SNZ_W-1:0] snz_left_q, snz_left_d;
    logic             timeout_q, timeout_d;
    logic             ld_err_q, ld_err_d;
    logic             match_q, match_d;
    logic             match_rise_q, match_rise_d;

    logic ld_ok;
    logic ring_clr, ring_tick, ring_last;
    logic snz_clr, snz_tick, snz_last;

    alarm_sec_cnt #(.LIMIT(RING_SECS)) u_ring_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (ring_clr),
        .tick    (ring_tick),
        .at_last (ring_last)
    );

    alarm_sec_cnt #(.LIMIT(SNOOZE_SECS)) u_snz_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (snz_clr),
        .tick    (snz_tick),
        .at_last (snz_last)
    );

    always_comb begin
        state_d    = state_q;
        mtens_d    = mtens_q;
        mones_d    = mones_q;
        stens_d    = stens_q;
        sones_d    = sones_q;
        blink_d    = blink_q;
        snz_left_d = snz_left_q;
        timeout_d  = 1'b0;
        ld_err_d   = 1'b0;
        ring_tick  = 1'b0;
        snz_tick   = 1'b0;

        ld_ok   = bcd_time_legal(ld_mtens, ld_mones, ld_stens, ld_sones);
        match_d = alarm_en && (t_mtens == mtens_q) && (t_mones == mones_q) &&
                  (t_stens == stens_q) && (t_sones == sones_q);
        // The rise is only captured while already ARMED, so a time that matches
        // at the moment of arming never rings; the capture register gives the
        // two-cycle match-to-ring latency.
        match_rise_d = match_d && !match_q && (state_q == ST_ARMED);

        if (ld_alarm) begin
            if (ld_ok) begin
                mtens_d = ld_mtens;
                mones_d = ld_mones;
                stens_d = ld_stens;
                sones_d = ld_sones;
            end else begin
                ld_err_d = 1'b1;
            end
        end

        if (!alarm_en) begin
            state_d = ST_DISARMED;
        end else if (ld_alarm) begin
            if (ld_ok && (state_q == ST_RINGING || state_q == ST_SNOOZING)) begin
                state_d = ST_ARMED;
            end
        end else begin
            unique case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match_rise_q) begin
                        state_d = ST_RINGING;
                    end
                end
                ST_RINGING: begin
                    if (key_dismiss) begin
                        state_d = ST_ARMED;
                    end else if (key_snooze && snz_left_q != '0) begin
                        state_d    = ST_SNOOZING;
                        snz_left_d = snz_left_q - 1'b1;
                    end else if (sec_tick) begin
                        blink_d   = ~blink_q;
                        ring_tick = 1'b1;
                        if (ring_last) begin
                            state_d   = ST_ARMED;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_SNOOZING: begin
                    if (key_dismiss) begin
                        state_d = ST_ARMED;
                    end else if (sec_tick) begin
                        snz_tick = 1'b1;
                        if (snz_last) begin
                            state_d = ST_RINGING;
                        end
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end

        // Blink restarts low on every entry into RINGING and is low elsewhere.
        if (state_d != ST_RINGING || state_q != ST_RINGING) begin
            blink_d = 1'b0;
        end
        if (state_d == ST_DISARMED || state_d == ST_ARMED) begin
            snz_left_d = SNZ_MAX;
        end

        // Counters run only while staying in their state; any entry starts at 0.
        ring_clr = !(state_q == ST_RINGING && state_d == ST_RINGING);
        snz_clr  = !(state_q == ST_SNOOZING && state_d == ST_SNOOZING);
        ring_d   = (state_d == ST_RINGING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DISARMED;
            mtens_q      <= '0;
            mones_q      <= '0;
            stens_q      <= '0;
            sones_q      <= '0;
            ring_q       <= 1'b0;
            blink_q      <= 1'b0;
            snz_left_q   <= SNZ_MAX;
            timeout_q    <= 1'b0;
            ld_err_q     <= 1'b0;
            match_q      <= 1'b0;
            match_rise_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mtens_q      <= mtens_d;
            mones_q      <= mones_d;
            stens_q      <= stens_d;
            sones_q      <= sones_d;
            ring_q       <= ring_d;
            blink_q      <= blink_d;
            snz_left_q   <= snz_left_d;
            timeout_q    <= timeout_d;
            ld_err_q     <= ld_err_d;
            match_q      <= match_d;
            match_rise_q <= match_rise_d;
        end
    end

    assign al_mtens     = mtens_q;
    assign al_mones     = mones_q;
    assign al_stens     = stens_q;
    assign al_sones     = sones_q;
    assign alarm_ring   = ring_q;
    assign alarm_blink  = blink_q;
    assign alarm_state  = state_q;
    assign snooze_left  = snz_left_q;
    assign ring_timeout = timeout_q;
    assign ld_err       = ld_err_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a seconds-level behavioural model.
module tb_alarm_sequencer;

    localparam int SNOOZE_SECS = 10;
    localparam int RING_SECS   = 30;
    localparam int MAX_SNOOZE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sec_tick = 1'b0, alarm_en = 1'b0, ld_alarm = 1'b0;
    logic [3:0] ld_mtens = '0, ld_mones = '0, ld_stens = '0, ld_sones = '0;
    logic [3:0] t_mtens = '0, t_mones = '0, t_stens = '0, t_sones = '0;
    logic       key_snooze = 1'b0, key_dismiss = 1'b0;
    logic [3:0] al_mtens, al_mones, al_stens, al_sones;
    logic       alarm_ring, alarm_blink, ring_timeout, ld_err;
    logic [1:0] alarm_state;
    logic [2:0] snooze_left;

    alarm_sequencer #(
        .SNOOZE_SECS (SNOOZE_SECS),
        .RING_SECS   (RING_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk (clk), .rst (rst), .sec_tick (sec_tick), .alarm_en (alarm_en),
        .ld_alarm (ld_alarm),
        .ld_mtens (ld_mtens), .ld_mones (ld_mones), .ld_stens (ld_stens), .ld_sones (ld_sones),
        .t_mtens (t_mtens), .t_mones (t_mones), .t_stens (t_stens), .t_sones (t_sones),
        .key_snooze (key_snooze), .key_dismiss (key_dismiss),
        .al_mtens (al_mtens), .al_mones (al_mones), .al_stens (al_stens), .al_sones (al_sones),
        .alarm_ring (alarm_ring), .alarm_blink (alarm_blink), .alarm_state (alarm_state),
        .snooze_left (snooze_left), .ring_timeout (ring_timeout), .ld_err (ld_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: state number, alarm digits, seconds elapsed in ring/snooze,
    // whether a fresh match was seen while armed (acted on next cycle).
    int m_state, m_ring_secs, m_snz_secs, m_left, m_blink, m_timeout, m_err;
    int m_prev_match, m_pending;
    int m_dig[4];
    int n_state, n_ring_secs, n_snz_secs, n_left, n_blink, n_timeout, n_err;
    int n_prev_match, n_pending;
    int n_dig[4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_ring_secs = 0; m_snz_secs = 0; m_left = MAX_SNOOZE;
        m_blink = 0; m_timeout = 0; m_err = 0; m_prev_match = 0; m_pending = 0;
        m_dig = '{0, 0, 0, 0};
    endtask

    task automatic model_next();
        bit legal;
        bit cur;
        legal = (ld_mtens <= 5) && (ld_mones <= 9) && (ld_stens <= 5) && (ld_sones <= 9);
        cur = alarm_en && (int'(t_mtens) == m_dig[0]) && (int'(t_mones) == m_dig[1]) &&
              (int'(t_stens) == m_dig[2]) && (int'(t_sones) == m_dig[3]);
        n_state = m_state; n_ring_secs = m_ring_secs; n_snz_secs = m_snz_secs;
        n_left = m_left; n_blink = m_blink; n_timeout = 0; n_err = 0;
        n_dig = m_dig;
        n_pending = (cur && !m_prev_match && m_state == 1) ? 1 : 0;
        n_prev_match = cur ? 1 : 0;

        if (ld_alarm) begin
            if (legal) n_dig = '{int'(ld_mtens), int'(ld_mones), int'(ld_stens), int'(ld_sones)};
            else n_err = 1;
        end

        if (!alarm_en) n_state = 0;
        else if (ld_alarm) begin
            if (legal && m_state >= 2) n_state = 1;
        end else if (m_state == 0) n_state = 1;
        else if (m_state == 1) begin
            if (m_pending != 0) begin n_state = 2; n_ring_secs = 0; n_blink = 0; end
        end else if (m_state == 2) begin
            if (key_dismiss) n_state = 1;
            else if (key_snooze && m_left > 0) begin
                n_state = 3; n_snz_secs = 0; n_left = m_left - 1;
            end else if (sec_tick) begin
                n_ring_secs = m_ring_secs + 1;
                n_blink = 1 - m_blink;
                if (n_ring_secs == RING_SECS) begin n_state = 1; n_timeout = 1; end
            end
        end else begin
            if (key_dismiss) n_state = 1;
            else if (sec_tick) begin
                n_snz_secs = m_snz_secs + 1;
                if (n_snz_secs == SNOOZE_SECS) begin n_state = 2; n_ring_secs = 0; n_blink = 0; end
            end
        end
        if (n_state != 2) n_blink = 0;
        if (n_state <= 1) n_left = MAX_SNOOZE;
    endtask

    task automatic compare_all();
        chk("state", int'(alarm_state), m_state);
        chk("ring", int'(alarm_ring), (m_state == 2) ? 1 : 0);
        chk("blink", int'(alarm_blink), m_blink);
        chk("snooze_left", int'(snooze_left), m_left);
        chk("ring_timeout", int'(ring_timeout), m_timeout);
        chk("ld_err", int'(ld_err), m_err);
        chk("al_mtens", int'(al_mtens), m_dig[0]);
        chk("al_mones", int'(al_mones), m_dig[1]);
        chk("al_stens", int'(al_stens), m_dig[2]);
        chk("al_sones", int'(al_sones), m_dig[3]);
    endtask

    // One clock cycle: model consumes current inputs, DUT samples them,
    // outputs compared 1 time unit after the edge, pulses dropped.
    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        m_state = n_state; m_ring_secs = n_ring_secs; m_snz_secs = n_snz_secs;
        m_left = n_left; m_blink = n_blink; m_timeout = n_timeout; m_err = n_err;
        m_prev_match = n_prev_match; m_pending = n_pending; m_dig = n_dig;
        compare_all();
        ld_alarm = 1'b0; key_snooze = 1'b0; key_dismiss = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic set_time(input int mt, input int mo, input int st, input int so);
        t_mtens = 4'(mt); t_mones = 4'(mo); t_stens = 4'(st); t_sones = 4'(so);
    endtask

    task automatic load(input int mt, input int mo, input int st, input int so);
        ld_mtens = 4'(mt); ld_mones = 4'(mo); ld_stens = 4'(st); ld_sones = 4'(so);
        ld_alarm = 1'b1;
        step();
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        step();
    endtask

    // Produce a fresh match edge on the current alarm time t, then wait for ring.
    task automatic rering(input int mt, input int mo, input int st, input int so);
        set_time(mt, mo, st, (so + 1) % 10);
        step();
        set_time(mt, mo, st, so);
        step();
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(alarm_state), 0);
        chk({tag, "_ring"}, int'(alarm_ring), 0);
        chk({tag, "_blink"}, int'(alarm_blink), 0);
        chk({tag, "_left"}, int'(snooze_left), MAX_SNOOZE);
        chk({tag, "_timeout"}, int'(ring_timeout), 0);
        chk({tag, "_ld_err"}, int'(ld_err), 0);
        chk({tag, "_digits"}, int'({al_mtens, al_mones, al_stens, al_sones}), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check_reset_values("reset");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Arm and load 00:10; clock approaches from 00:09.
        alarm_en = 1'b1;
        set_time(0, 0, 0, 9);
        step();
        chk("armed_lit", int'(alarm_state), 1);
        load(0, 0, 1, 0);
        chk("load_lit", int'({al_mtens, al_mones, al_stens, al_sones}), 16'h0010);
        step();
        key_snooze = 1'b1;               // keys in ARMED are ignored
        step();
        chk("key_armed_lit", int'(alarm_state), 1);

        set_time(0, 0, 1, 0);
        step();
        chk("lat1_ring_lit", int'(alarm_ring), 0);
        step();
        chk("lat2_ring_lit", int'(alarm_ring), 1);
        chk("lat2_state_lit", int'(alarm_state), 2);

        // Blink on each tick, timeout on the 30th.
        tick();
        chk("blink1_lit", int'(alarm_blink), 1);
        tick();
        chk("blink2_lit", int'(alarm_blink), 0);
        for (int i = 3; i <= RING_SECS; i++) begin
            sec_tick = 1'b1;
            step();
            if (i == RING_SECS) begin
                chk("timeout_pulse_lit", int'(ring_timeout), 1);
                chk("timeout_state_lit", int'(alarm_state), 1);
            end
            step();
        end
        chk("timeout_gone_lit", int'(ring_timeout), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("no_rering_lit", int'(alarm_state), 1);

        // Snooze three times, fourth press ignored.
        rering(0, 0, 1, 0);
        for (int s = 1; s <= 4; s++) begin
            key_snooze = 1'b1;
            step();
            if (s < 4) begin
                chk("snooze_left_lit", int'(snooze_left), MAX_SNOOZE - s);
                chk("snoozing_lit", int'(alarm_state), 3);
                for (int k = 0; k < SNOOZE_SECS; k++) tick();
                chk("resume_lit", int'(alarm_state), 2);
            end else begin
                chk("snooze4_ignored_lit", int'(alarm_state), 2);
            end
        end

        // Illegal load while ringing, then legal load 01:00.
        load(6, 0, 1, 0);
        chk("ld_err_lit", int'(ld_err), 1);
        chk("ld_err_state_lit", int'(alarm_state), 2);
        step();
        load(0, 1, 0, 0);
        chk("ld_ok_state_lit", int'(alarm_state), 1);
        chk("ld_ok_digits_lit", int'({al_mtens, al_mones, al_stens, al_sones}), 16'h0100);

        // Dismiss beats snooze in the same cycle.
        rering(0, 1, 0, 0);
        key_snooze = 1'b1;
        step();
        for (int k = 0; k < SNOOZE_SECS; k++) tick();
        key_snooze = 1'b1;
        key_dismiss = 1'b1;
        step();
        chk("dismiss_wins_lit", int'(alarm_state), 1);
        chk("dismiss_left_lit", int'(snooze_left), MAX_SNOOZE);

        // Drop alarm_en while snoozing; re-arm with time already matching.
        rering(0, 1, 0, 0);
        key_snooze = 1'b1;
        step();
        alarm_en = 1'b0;
        step();
        chk("disarm_lit", int'(alarm_state), 0);
        alarm_en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("arm_on_match_lit", int'(alarm_state), 1);

        // Asynchronous reset mid-ring.
        rering(0, 1, 0, 0);
        chk("pre_reset_ring_lit", int'(alarm_ring), 1);
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
